// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared mode encoding, LED width and mode sequencing helper
package led_ctrl_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        STEP   = 2'd1,
        RUN_UP = 2'd2,
        RUN_DN = 2'd3
    } mode_e;

    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces an active-low button, pulses once per accepted press
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [1:0]    vld;
    logic [CW-1:0] cnt;
    logic          level_d;
    logic          armed;

    // presses only count once the button has been seen released after reset, so a button held through reset is ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            vld     <= 2'b00;
            cnt     <= '0;
            level   <= 1'b1;
            level_d <= 1'b1;
            armed   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync    <= {sync[0], btn_n};
            vld     <= {vld[0], 1'b1};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
            level_d <= level;
            armed   <= armed | (vld[1] & sync[1] & level);
            press   <= armed & level_d & ~level;
        end
    end

endmodule

// File: rtl/led_counter_ctrl.sv
// led_counter_ctrl: debounced two-button mode FSM driving a hold/step/auto-run 4-bit LED counter
module led_counter_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int TICK_CYCLES     = 1200000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_mode_n,
    input  logic             btn_step_n,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             tick
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PLAST = PW'(TICK_CYCLES - 1);

    mode_e            state, state_nx;
    logic [LED_W-1:0] led_nx;
    logic [PW-1:0]    presc, presc_nx;
    logic             mode_press, step_press, run;
    logic             unused_mode_level, unused_step_level;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_mode_n),
        .level (unused_mode_level),
        .press (mode_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_step_n),
        .level (unused_step_level),
        .press (step_press)
    );

    assign run  = (state == RUN_UP) || (state == RUN_DN);
    assign tick = run && (presc == PLAST);
    assign mode = state;

    // mode, counter and prescaler registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HOLD;
            led   <= '0;
            presc <= '0;
        end else begin
            state <= state_nx;
            led   <= led_nx;
            presc <= presc_nx;
        end
    end

    // priority: mode press, then step press, then tick; any of them restarts the prescaler
    always_comb begin
        state_nx = state;
        led_nx   = led;
        presc_nx = run ? presc + PW'(1) : '0;
        if (mode_press) begin
            state_nx = next_mode(state);
            presc_nx = '0;
        end else if (step_press && state == STEP) begin
            led_nx = led + LED_W'(1);
        end else if (step_press && run) begin
            led_nx   = '0;
            presc_nx = '0;
        end else if (tick) begin
            led_nx   = (state == RUN_UP) ? led + LED_W'(1) : led - LED_W'(1);
            presc_nx = '0;
        end
    end

endmodule
